// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types, defaults and helpers for the clock divider
// Purpose: controller state encoding, default widths/limits and the high-phase
//          length helper used by the divider core.
package clk_div_pkg;

    localparam int CNT_W_DEF   = 28;
    localparam int MIN_DIV_DEF = 2;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    // High-phase length of a period; odd divisors give the extra cycle to the low phase.
    // Handles divisor widths up to 32 bits.
    function automatic logic [31:0] half_div(input logic [31:0] div);
        return div >> 1;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - period counter with load-on-wrap divisor and registered decode
// Purpose: counts 0..div-1 while active, loads a new divisor when told to, and
//          registers clock_out/tick from the counter value of the coming cycle.
// Ports:
//   clock_in, rst_n   clock and asynchronous active-low reset
//   i_active          controller is in RUN/STEP this cycle (counter advances)
//   i_next_active     controller will be in RUN/STEP next cycle (decode enabled)
//   i_div_we          load i_div_wdata into the active divisor at this edge
//   i_div_wdata       divisor to load
//   o_clock_out       divided clock (flop)
//   o_tick            last-cycle-of-period pulse (flop)
//   o_wrap            wrap strobe for the controller (same flop as o_tick)
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 400000
) (
    input  logic             clock_in,
    input  logic             rst_n,
    input  logic             i_active,
    input  logic             i_next_active,
    input  logic             i_div_we,
    input  logic [CNT_W-1:0] i_div_wdata,
    output logic             o_clock_out,
    output logic             o_tick,
    output logic             o_wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic             r_clock_out;
    logic             r_tick;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_half_nxt;
    logic             w_clock_out_nxt;
    logic             w_tick_nxt;

    // Decode is computed from the next counter/divisor so the output flops
    // line up with the counter value of the cycle they describe.
    always_comb begin
        w_cnt_nxt = '0;
        if (i_active && !r_tick) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        w_div_nxt       = i_div_we ? i_div_wdata : r_div;
        w_half_nxt      = CNT_W'(half_div(32'(w_div_nxt)));
        w_clock_out_nxt = i_next_active && (w_cnt_nxt < w_half_nxt);
        w_tick_nxt      = i_next_active && (w_cnt_nxt == (w_div_nxt - CNT_W'(1)));
    end

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_div       <= CNT_W'(DEFAULT_DIV);
            r_clock_out <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_div       <= w_div_nxt;
            r_clock_out <= w_clock_out_nxt;
            r_tick      <= w_tick_nxt;
        end
    end

    // tick is only ever set while active, so it doubles as the wrap strobe.
    assign o_clock_out = r_clock_out;
    assign o_tick      = r_tick;
    assign o_wrap      = r_tick;

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run/stop/step controller and divisor handshake around clk_div_core
// Purpose: sequences STOP/RUN/STEP, accepts divisor requests over valid/ready and
//          applies them only at period boundaries.
// Ports:
//   clock_in, rst_n   clock and asynchronous active-low reset
//   run               level: free-run when 1, stop at end of period when 0
//   step              pulse: in STOP, run one period
//   cfg_valid/cfg_div divisor request
//   cfg_ready         request can be accepted this cycle (flop)
//   cfg_err           accepted request was below MIN_DIV (flop, one cycle)
//   clock_out, tick   divided clock and last-cycle pulse (flops)
//   running           1 in RUN/STEP (flop)
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 400000,
    parameter int MIN_DIV     = MIN_DIV_DEF
) (
    input  logic             clock_in,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clock_out,
    output logic             tick,
    output logic             running
);

    state_t           r_state;
    logic             r_pend;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_cfg_ready;
    logic             r_cfg_err;
    logic             r_running;

    state_t           w_state_nxt;
    logic             w_pend_nxt;
    logic [CNT_W-1:0] w_pend_div_nxt;
    logic             w_cfg_ready_nxt;
    logic             w_cfg_err_nxt;
    logic             w_running_nxt;
    logic             w_div_we;
    logic [CNT_W-1:0] w_div_wdata;
    logic             w_xfer;
    logic             w_legal;
    logic             w_wrap;

    assign w_xfer  = cfg_valid && r_cfg_ready;
    assign w_legal = (cfg_div >= CNT_W'(MIN_DIV));

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= STOP;
            r_pend      <= 1'b0;
            r_pend_div  <= '0;
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_div  <= w_pend_div_nxt;
            r_cfg_ready <= w_cfg_ready_nxt;
            r_cfg_err   <= w_cfg_err_nxt;
            r_running   <= w_running_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pend_nxt     = r_pend;
        w_pend_div_nxt = r_pend_div;
        w_div_we       = 1'b0;
        w_div_wdata    = cfg_div;

        case (r_state)
            STOP: begin
                if (run) begin
                    w_state_nxt = RUN;
                end else if (step) begin
                    w_state_nxt = STEP;
                end
                if (w_xfer && w_legal) begin
                    w_div_we = 1'b1;
                end
            end
            RUN, STEP: begin
                if (w_wrap) begin
                    // A value parked earlier wins; cfg_ready was low so no
                    // transfer can collide with it in this cycle.
                    w_state_nxt = run ? RUN : STOP;
                    w_pend_nxt  = 1'b0;
                    if (r_pend) begin
                        w_div_we    = 1'b1;
                        w_div_wdata = r_pend_div;
                    end else if (w_xfer && w_legal) begin
                        w_div_we = 1'b1;
                    end
                end else if (w_xfer && w_legal) begin
                    w_pend_nxt     = 1'b1;
                    w_pend_div_nxt = cfg_div;
                end
            end
            default: begin
                w_state_nxt = STOP;
                w_pend_nxt  = 1'b0;
            end
        endcase

        w_cfg_ready_nxt = (w_state_nxt == STOP) || !w_pend_nxt;
        w_cfg_err_nxt   = w_xfer && !w_legal;
        w_running_nxt   = (w_state_nxt != STOP);
    end

    clk_div_core #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_core (
        .clock_in      (clock_in),
        .rst_n         (rst_n),
        .i_active      (r_state != STOP),
        .i_next_active (w_state_nxt != STOP),
        .i_div_we      (w_div_we),
        .i_div_wdata   (w_div_wdata),
        .o_clock_out   (clock_out),
        .o_tick        (tick),
        .o_wrap        (w_wrap)
    );

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;
    assign running   = r_running;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - self-checking bench for clk_div_ctrl with a behavioural model
module tb_clk_div_ctrl;

    localparam int CNT_W   = 28;
    localparam int DEF_DIV = 10;

    logic             clock_in = 1'b0;
    logic             rst_n;
    logic             run;
    logic             step;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clock_out;
    logic             tick;
    logic             running;

    int n_tests = 0;
    int n_fail  = 0;

    clk_div_ctrl #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV),
        .MIN_DIV     (2)
    ) dut (
        .clock_in  (clock_in),
        .rst_n     (rst_n),
        .run       (run),
        .step      (step),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clock_out (clock_out),
        .tick      (tick),
        .running   (running)
    );

    always #5 clock_in = ~clock_in;

    // Behavioural model: mode 0 = stopped, 1 = free-running, 2 = single period.
    // m_pos is the position inside the current period.
    int m_mode     = 0;
    int m_pos      = 0;
    int m_div      = DEF_DIV;
    bit m_pend     = 1'b0;
    int m_pend_div = 0;
    bit m_err      = 1'b0;

    function automatic bit m_ready();
        return (m_mode == 0) || !m_pend;
    endfunction

    always @(posedge clock_in or negedge rst_n) begin : model
        bit acc;
        bit legal;
        if (!rst_n) begin
            m_mode = 0;
            m_pos  = 0;
            m_div  = DEF_DIV;
            m_pend = 1'b0;
            m_err  = 1'b0;
        end else begin
            acc   = cfg_valid && m_ready();
            legal = (cfg_div >= 28'd2);
            m_err = acc && !legal;
            if (m_mode == 0) begin
                m_pos = 0;
                if (acc && legal) m_div = int'(cfg_div);
                if (run) m_mode = 1;
                else if (step) m_mode = 2;
            end else if (m_pos + 1 == m_div) begin
                if (m_pend) m_div = m_pend_div;
                else if (acc && legal) m_div = int'(cfg_div);
                m_pend = 1'b0;
                m_pos  = 0;
                m_mode = run ? 1 : 0;
            end else begin
                m_pos = m_pos + 1;
                if (acc && legal) begin
                    m_pend     = 1'b1;
                    m_pend_div = int'(cfg_div);
                end
            end
        end
    end

    task automatic cmp(input string name, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    always @(negedge clock_in) begin
        cmp("clock_out", clock_out, (m_mode != 0) && (m_pos < m_div / 2));
        cmp("tick",      tick,      (m_mode != 0) && (m_pos == m_div - 1));
        cmp("running",   running,   m_mode != 0);
        cmp("cfg_ready", cfg_ready, m_ready());
        cmp("cfg_err",   cfg_err,   m_err);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clock_in);
        #1;
    endtask

    logic [31:0] v_clk, v_tick, v_rdy, v_run;

    initial begin
        rst_n     = 1'b0;
        run       = 1'b0;
        step      = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        repeat (3) cyc();
        rst_n = 1'b1;
        chk("rst_clock_out", 32'(clock_out), 32'h0);
        chk("rst_tick",      32'(tick),      32'h0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);
        chk("rst_cfg_err",   32'(cfg_err),   32'h0);
        chk("rst_running",   32'(running),   32'h0);

        // Free-run at the default divisor: 5 high / 5 low, tick on the 10th cycle.
        v_clk = '0; v_tick = '0;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            v_clk[i] = clock_out; v_tick[i] = tick;
        end
        chk("t1_clk",  v_clk,  32'h07C1F);
        chk("t1_tick", v_tick, 32'h80200);

        // Divisor 4 requested at counter 3; takes effect after the current period.
        repeat (4) cyc();
        chk("t2_ready_before", 32'(cfg_ready), 32'h1);
        cfg_valid = 1'b1; cfg_div = 28'd4;
        v_clk = '0; v_tick = '0; v_rdy = '0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            if (i == 0) cfg_valid = 1'b0;
            v_clk[i] = clock_out; v_tick[i] = tick; v_rdy[i] = cfg_ready;
        end
        chk("t2_clk",   v_clk,  32'h0CC1);
        chk("t2_tick",  v_tick, 32'h2220);
        chk("t2_ready", v_rdy,  32'h3FC0);

        // Handshake in the tick cycle: the very next period uses divisor 7.
        cfg_valid = 1'b1; cfg_div = 28'd7;
        v_clk = '0; v_tick = '0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 0) cfg_valid = 1'b0;
            v_clk[i] = clock_out; v_tick[i] = tick;
        end
        chk("t4_clk",  v_clk,  32'h87);
        chk("t4_tick", v_tick, 32'h40);

        // Drop run at counter 2 with a divisor request: period completes, value kept.
        repeat (2) cyc();
        run = 1'b0; cfg_valid = 1'b1; cfg_div = 28'd10;
        v_clk = '0; v_tick = '0; v_rdy = '0; v_run = '0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 0) cfg_valid = 1'b0;
            v_clk[i] = clock_out; v_tick[i] = tick; v_rdy[i] = cfg_ready; v_run[i] = running;
        end
        chk("t6_clk",     v_clk,  32'h00);
        chk("t6_tick",    v_tick, 32'h08);
        chk("t6_ready",   v_rdy,  32'h10);
        chk("t6_running", v_run,  32'h0F);

        // Illegal divisor in STOP: error pulse only.
        cfg_valid = 1'b1; cfg_div = 28'd1;
        cyc();
        cfg_valid = 1'b0;
        chk("t3_err_pulse", 32'(cfg_err),   32'h1);
        chk("t3_ready",     32'(cfg_ready), 32'h1);
        cyc();
        chk("t3_err_clear", 32'(cfg_err),   32'h0);

        // Single step: one 10-cycle period then back to STOP.
        step = 1'b1;
        v_clk = '0; v_tick = '0; v_run = '0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (i == 0) step = 1'b0;
            v_clk[i] = clock_out; v_tick[i] = tick; v_run[i] = running;
        end
        chk("t5_clk",     v_clk,  32'h01F);
        chk("t5_tick",    v_tick, 32'h200);
        chk("t5_running", v_run,  32'h3FF);

        // Asynchronous reset mid-period with a pending divisor.
        run = 1'b1;
        repeat (3) cyc();
        cfg_valid = 1'b1; cfg_div = 28'd4;
        cyc();
        cfg_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6r_clock_out", 32'(clock_out), 32'h0);
        chk("t6r_running",   32'(running),   32'h0);
        chk("t6r_cfg_ready", 32'(cfg_ready), 32'h1);
        repeat (2) cyc();
        rst_n = 1'b1;
        v_clk = '0; v_tick = '0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            v_clk[i] = clock_out; v_tick[i] = tick;
        end
        chk("t6r_clk",  v_clk,  32'h01F);
        chk("t6r_tick", v_tick, 32'h200);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if ($urandom_range(0, 19) == 0) run = ~run;
            step      = ($urandom_range(0, 7) == 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_div   = CNT_W'($urandom_range(0, 12));
        end
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
